// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, controller state encoding and message-schedule sigma functions.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINAL,
        ST_DONE
    } state_e;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // s0 = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // s1 = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_compress_ctrl_if.sv
// Block/digest handshake and round-datapath bus of the compression controller.
interface sha256_compress_ctrl_if;

    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_m;
    logic [255:0] h_in;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_out;
    logic         rnd_in_valid;
    logic         rnd_out_ready;
    logic [255:0] rnd_abcdefgh_i;
    logic [31:0]  rnd_k;
    logic [31:0]  rnd_w;
    logic         rnd_out_valid;
    logic [255:0] rnd_abcdefgh_o;

    // Controller side.
    modport slave (
        input  blk_valid, blk_m, h_in, dig_ready, rnd_out_valid, rnd_abcdefgh_o,
        output blk_ready, dig_valid, dig_out, rnd_in_valid, rnd_out_ready,
               rnd_abcdefgh_i, rnd_k, rnd_w
    );

    // Producer/consumer and round-datapath side.
    modport master (
        output blk_valid, blk_m, h_in, dig_ready, rnd_out_valid, rnd_abcdefgh_o,
        input  blk_ready, dig_valid, dig_out, rnd_in_valid, rnd_out_ready,
               rnd_abcdefgh_i, rnd_k, rnd_w
    );

endinterface

// File: rtl/sha256_wsched.sv
// 16-word message-schedule ring: slot j mod 16 holds W[j]; W_t is generated in place for t >= 16.
module sha256_wsched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         load_i,
    input  logic [511:0] blk_m_i,
    input  logic         issue_i,
    input  logic [5:0]   t_i,
    output logic [31:0]  w_o
);

    logic [31:0] ring_q [16];
    logic [31:0] w_new;
    logic [3:0]  idx, idx_m2, idx_m7, idx_m15;
    logic        gen;

    // 4-bit index arithmetic makes the ring wrap 15 -> 0 for free.
    assign idx     = t_i[3:0];
    assign idx_m2  = idx - 4'd2;
    assign idx_m7  = idx - 4'd7;
    assign idx_m15 = idx + 4'd1;
    assign gen     = (t_i[5:4] != 2'b00);

    assign w_new = s1(ring_q[idx_m2]) + ring_q[idx_m7] + s0(ring_q[idx_m15]) + ring_q[idx];

    // After the ISSUE write the slot already holds W_t, so the output stays stable through WAIT.
    assign w_o = (issue_i && gen) ? w_new : ring_q[idx];

    // NOTE: the ring is always loaded from the block before it is read, so it has no reset.
    // NOTE: clocked state is assigned with <= only, so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int i = 0; i < 16; i++) begin
                ring_q[i] <= blk_m_i[511 - 32*i -: 32];
            end
        end else if (issue_i && gen) begin
            ring_q[idx] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression controller: sequences 64 rounds over an external round datapath.
module sha256_compress_ctrl
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    sha256_compress_ctrl_if.slave  bus
);

    state_e       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic         blk_ready_q;
    logic [255:0] h_q, work_q, dig_q, dig_sum;
    logic         accept, rnd_done;

    assign accept   = (state_q == ST_IDLE) && blk_ready_q && bus.blk_valid;
    assign rnd_done = (state_q == ST_WAIT) && bus.rnd_out_valid;

    // blk_ready is registered so it stays low during reset and rises one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            blk_ready_q <= 1'b0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            blk_ready_q <= (state_d == ST_IDLE);
            if (state_q == ST_FINAL) begin
                dig_q <= dig_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            h_q    <= bus.h_in;
            work_q <= bus.h_in;
        end else if (rnd_done) begin
            work_q <= bus.rnd_abcdefgh_o;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    t_d     = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.rnd_out_valid) begin
                    if (t_q == 6'd63) begin
                        state_d = ST_FINAL;
                    end else begin
                        t_d     = t_q + 6'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.dig_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.rnd_in_valid  = 1'b0;
        bus.rnd_out_ready = 1'b0;
        bus.dig_valid     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                bus.rnd_in_valid  = 1'b1;
                bus.rnd_out_ready = 1'b1;
            end
            ST_WAIT:  bus.rnd_out_ready = 1'b1;
            ST_DONE:  bus.dig_valid     = 1'b1;
            default:  ;
        endcase
    end

    // Per-word modular add; no carry crosses word boundaries.
    always_comb begin
        dig_sum = '0;
        for (int i = 0; i < 8; i++) begin
            dig_sum[255 - 32*i -: 32] = h_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
        end
    end

    assign bus.blk_ready      = blk_ready_q;
    assign bus.dig_out        = dig_q;
    assign bus.rnd_abcdefgh_i = work_q;
    assign bus.rnd_k          = K_TABLE[t_q];

    sha256_wsched u_wsched (
        .clk     (clk),
        .load_i  (accept),
        .blk_m_i (bus.blk_m),
        .issue_i (state_q == ST_ISSUE),
        .t_i     (t_q),
        .w_o     (bus.rnd_w)
    );

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Bench for sha256_compress_ctrl: behavioural round datapath, digest scoreboard, schedule monitor.
`timescale 1ns/1ps
module tb_sha256_compress_ctrl;
    import sha256_pkg::SHA256_IV;

    localparam logic [511:0] ABC_MSG   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_MSG = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_DIG   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha256_compress_ctrl_if bus ();

    sha256_compress_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int fails     = 0;
    logic [255:0] sb_q [$];
    int pulse_cnt = 0;
    int accepts   = 0;
    int dig_cnt   = 0;
    logic [31:0] exp_w [64];

    int pend = 0;
    logic [255:0] cap_abc;
    logic [31:0]  cap_k, cap_w;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x); return rr(x, 2) ^ rr(x, 13) ^ rr(x, 22); endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x); return rr(x, 6) ^ rr(x, 11) ^ rr(x, 25); endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x); return rr(x, 7) ^ rr(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x); return rr(x, 17) ^ rr(x, 19) ^ (x >> 10); endfunction

    function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bs1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Round datapath: answers each issue pulse two cycles later with a one-cycle valid.
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            bus.rnd_out_valid  = 1'b0;
            bus.rnd_abcdefgh_o = '0;
        end else begin
            bus.rnd_out_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tests_run++;
                    if (bus.rnd_abcdefgh_i !== cap_abc || bus.rnd_k !== cap_k || bus.rnd_w !== cap_w) begin
                        fails++;
                        $display("FAIL round_inputs_stable: got k=%h w=%h abc=%h, required k=%h w=%h abc=%h",
                                 bus.rnd_k, bus.rnd_w, bus.rnd_abcdefgh_i, cap_k, cap_w, cap_abc);
                    end
                    bus.rnd_abcdefgh_o = round_fn(cap_abc, cap_k, cap_w);
                    bus.rnd_out_valid  = 1'b1;
                end
            end
            if (bus.rnd_in_valid) begin
                cap_abc = bus.rnd_abcdefgh_i;
                cap_k   = bus.rnd_k;
                cap_w   = bus.rnd_w;
                pend    = 2;
            end
        end
    end

    // Accept / issue / digest monitor with schedule model and digest scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            pulse_cnt = 0;
        end else begin
            if (bus.blk_valid && bus.blk_ready) begin
                accepts++;
                pulse_cnt = 0;
                for (int i = 0; i < 16; i++) exp_w[i] = bus.blk_m[511 - 32*i -: 32];
                for (int i = 16; i < 64; i++)
                    exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
            end
            if (bus.rnd_in_valid) begin
                tests_run++;
                if (pulse_cnt >= 64) begin
                    fails++;
                    $display("FAIL rnd_pulse_extra: got pulse %0d, required at most 64", pulse_cnt + 1);
                end else if (bus.rnd_w !== exp_w[pulse_cnt] || bus.rnd_out_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL rnd_w t=%0d: got w=%h ready=%b, required w=%h ready=1",
                             pulse_cnt, bus.rnd_w, bus.rnd_out_ready, exp_w[pulse_cnt]);
                end
                if (pulse_cnt == 63) begin
                    tests_run++;
                    if (bus.rnd_k !== 32'hc67178f2) begin
                        fails++;
                        $display("FAIL rnd_k_t63: got %h, required c67178f2", bus.rnd_k);
                    end
                end
                pulse_cnt++;
            end
            if (bus.dig_valid && bus.dig_ready) begin
                logic [255:0] exp_d;
                dig_cnt++;
                tests_run++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL dig_unexpected: got digest %h, required none", bus.dig_out);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (bus.dig_out !== exp_d) begin
                        fails++;
                        $display("FAIL dig_out: got %h, required %h", bus.dig_out, exp_d);
                    end
                end
                tests_run++;
                if (pulse_cnt != 64) begin
                    fails++;
                    $display("FAIL rnd_pulse_count: got %0d, required 64", pulse_cnt);
                end
            end
        end
    end

    task automatic offer(input logic [511:0] m, input logic [255:0] exp_d);
        bit ok = 1'b0;
        bus.blk_m     = m;
        bus.h_in      = SHA256_IV;
        bus.blk_valid = 1'b1;
        sb_q.push_back(exp_d);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = bus.blk_ready;
        end
        @(posedge clk); #1;
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: blk_ready=0 after 400 cycles, required 1");
        end
    endtask

    task automatic wait_digest(input int limit, output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = bus.dig_valid;
        end
        tests_run++;
        if (!seen) begin
            fails++;
            $display("FAIL dig_valid_timeout: no dig_valid in %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.blk_ready, bus.dig_valid, bus.rnd_in_valid, bus.rnd_out_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy/dv/iv/or=%b, required 0000",
                     {bus.blk_ready, bus.dig_valid, bus.rnd_in_valid, bus.rnd_out_ready});
        end
        tests_run++;
        if (bus.dig_out !== 256'h0) begin
            fails++;
            $display("FAIL reset_dig_out: got %h, required 0", bus.dig_out);
        end
        tests_run++;
        if (bus.rnd_k !== 32'h428a2f98) begin
            fails++;
            $display("FAIL reset_t0_k: got %h, required 428a2f98", bus.rnd_k);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b, required 0", bus.blk_ready);
        end
        @(negedge clk);
        tests_run++;
        if (bus.blk_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_edge: got %b, required 1", bus.blk_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_digest(input string name, input logic [511:0] m, input logic [255:0] exp_d);
        int n;
        bus.dig_ready = 1'b1;
        offer(m, exp_d);
        bus.blk_valid = 1'b0;
        wait_digest(400, n);
        tests_run++;
        if (n != 194) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles, required 194", name, n);
        end
        @(posedge clk); #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d pending digests, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_stall();
        int n;
        int d0;
        bus.dig_ready = 1'b0;
        offer(ABC_MSG, ABC_DIG);
        bus.blk_valid = 1'b0;
        wait_digest(400, n);
        d0 = dig_cnt;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) @(negedge clk);
            tests_run++;
            if (bus.dig_out !== ABC_DIG || bus.dig_valid !== 1'b1 || bus.blk_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold cyc=%0d: got dv=%b rdy=%b dig=%h, required dv=1 rdy=0 dig=%h",
                         i, bus.dig_valid, bus.blk_ready, bus.dig_out, ABC_DIG);
            end
        end
        @(posedge clk); #1;
        bus.dig_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.blk_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_ready_in_handshake: got %b, required 0", bus.blk_ready);
        end
        @(negedge clk);
        tests_run++;
        if (bus.dig_valid !== 1'b0 || bus.blk_ready !== 1'b1 || dig_cnt != d0 + 1) begin
            fails++;
            $display("FAIL stall_release: got dv=%b rdy=%b digests=%0d, required dv=0 rdy=1 digests=%0d",
                     bus.dig_valid, bus.blk_ready, dig_cnt - d0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        int a0 = accepts;
        int d0 = dig_cnt;
        bus.dig_ready = 1'b0;
        offer(ABC_MSG, ABC_DIG);
        wait_digest(400, n);
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (accepts != a0 + 1) begin
            fails++;
            $display("FAIL b2b_busy_ignore: got %0d accepts, required 1", accepts - a0);
        end
        @(posedge clk); #1;
        bus.dig_ready = 1'b1;
        bus.blk_m     = EMPTY_MSG;
        sb_q.push_back(EMPTY_DIG);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        bus.blk_valid = 1'b0;
        tests_run++;
        if (accepts != a0 + 2) begin
            fails++;
            $display("FAIL b2b_second_accept: got %0d accepts, required 2", accepts - a0);
        end
        wait_digest(400, n);
        @(posedge clk); #1;
        tests_run++;
        if (dig_cnt != d0 + 2 || sb_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_digests: got %0d digests with %0d pending, required 2 with 0",
                     dig_cnt - d0, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0 = dig_cnt;
        bit saw = 1'b0;
        bus.dig_ready = 1'b1;
        offer(ABC_MSG, ABC_DIG);
        bus.blk_valid = 1'b0;
        while (pulse_cnt < 30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (pulse_cnt < 30) begin
            fails++;
            $display("FAIL mid_reach_round30: got %0d rounds, required 30", pulse_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        tests_run++;
        if ({bus.blk_ready, bus.dig_valid, bus.rnd_in_valid, bus.rnd_out_ready} !== 4'b0000 ||
            bus.dig_out !== 256'h0) begin
            fails++;
            $display("FAIL mid_reset_state: got rdy/dv/iv/or=%b dig=%h, required 0000 and 0",
                     {bus.blk_ready, bus.dig_valid, bus.rnd_in_valid, bus.rnd_out_ready}, bus.dig_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (bus.dig_valid) saw = 1'b1;
        end
        tests_run++;
        if (saw || dig_cnt != d0) begin
            fails++;
            $display("FAIL mid_no_digest: got dig_valid seen=%b digests=%0d, required 0 and 0",
                     saw, dig_cnt - d0);
        end
        @(posedge clk); #1;
        test_digest("abc_after_reset", ABC_MSG, ABC_DIG);
    endtask

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_m     = '0;
        bus.h_in      = '0;
        bus.dig_ready = 1'b0;
        test_reset();
        test_digest("abc", ABC_MSG, ABC_DIG);
        test_digest("empty", EMPTY_MSG, EMPTY_DIG);
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_compress_ctrl.md
SHA256_COMPRESS_CTRL -- requirements
Module: sha256_compress_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous reset, active-high
- blk_valid  in  1  message block and chaining value offered
- blk_ready  out  1  controller idle, can accept a block
- blk_m  in  512  padded block, word 0 = bits 511:480 (big-endian)
- h_in  in  256  chaining value H0..H7, H0 = bits 255:224
- dig_valid  out  1  digest available
- dig_ready  in  1  consumer accepts digest
- dig_out  out  256  H_in + final working variables, same packing as h_in
- rnd_in_valid  out  1  issue pulse to the round datapath
- rnd_out_ready  out  1  result acceptance to the round datapath
- rnd_abcdefgh_i  out  256  working variables a..h to the round, a = bits 255:224
- rnd_k  out  32  K_t for the current round
- rnd_w  out  32  W_t for the current round
- rnd_out_valid  in  1  round result valid
- rnd_abcdefgh_o  in  256  updated a..h from the round, same packing
REQ-002 There SHALL be one clock and an asynchronous, active-high reset; there SHALL be no parameters.

Function
REQ-003 States SHALL be IDLE, ISSUE, WAIT, FINAL and DONE, with a 6-bit round counter t.
REQ-004 IDLE: blk_ready=1; on blk_valid&&blk_ready, capture blk_m into the 16-word W ring, h_in into H, a..h<=h_in, t<=0, then go to ISSUE.
REQ-005 ISSUE: rnd_in_valid=1 for exactly one cycle, then go to WAIT; rnd_in_ready is not part of this interface.
REQ-006 rnd_abcdefgh_i, rnd_k and rnd_w SHALL be held stable from ISSUE until the cycle rnd_out_valid is sampled in WAIT.
REQ-007 rnd_out_ready SHALL be 1 in ISSUE and WAIT and 0 otherwise.
REQ-008 WAIT: on rnd_out_valid, a..h<=rnd_abcdefgh_o. If t==63, go to FINAL. Otherwise t<=t+1 and go to ISSUE.
REQ-009 rnd_out_valid seen outside WAIT SHALL be ignored.
REQ-010 W_t for t<16 SHALL be message word t. For t>=16, W_t = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32, where:
- s0 = ROTR7^ROTR18^SHR3
- s1 = ROTR17^ROTR19^SHR10
REQ-011 For t>=16, W_t SHALL be written into ring slot t mod 16 at ISSUE. The ring index SHALL wrap 15->0.
REQ-012 rnd_k SHALL be K[t] from the 64-entry FIPS 180-4 constant table.
REQ-013 FINAL: dig_out word i <= H[i] + working var i, mod 2^32 per word with no inter-word carry, then go to DONE; this takes one cycle.
REQ-014 DONE: dig_valid=1 and dig_out held until dig_valid&&dig_ready, then go to IDLE. blk_ready stays 0 until that cycle has passed.
REQ-015 Latency from block accept to dig_valid SHALL be 64 round transactions + 2 cycles. With a round that responds 2 cycles after the pulse, this is 64*3+2 = 194 cycles.
REQ-016 blk_valid while busy SHALL be ignored with no capture. dig_ready held low SHALL stall indefinitely in DONE without loss.

Reset
REQ-017 While rst=1 (async assert), the block SHALL go to state IDLE with:
- t=0
- blk_ready=0
- dig_valid=0, rnd_in_valid=0, rnd_out_ready=0
- dig_out=0
REQ-018 blk_ready SHALL become 1 on the first clk edge after rst deasserts.
REQ-019 Reset mid-operation SHALL abandon the block with no digest produced. The W ring and a..h need no reset.

Structure
REQ-020 A shared package sha256_pkg SHALL hold:
- the K table (64x32)
- the IV constants
- the state enum
- the s0/s1 functions, shared with any schedule logic
REQ-021 One sub-module is natural: sha256_wsched (16-word ring plus W_t generator, indexed by t).

Verification
REQ-022 Directed scenarios:
- "abc" block 61626380_00..00_00000018 with h_in = IV -> dig_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty block 80000000_00..00 with IV -> dig_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- dig_ready low for 50 cycles after dig_valid -> dig_out stable, blk_ready=0, then a single accept.
- blk_valid held high throughout a computation -> exactly one digest per accepted block; a second block is accepted only after the digest is taken.
- rst pulsed at round 30 -> dig_valid never asserted; the next "abc" run gives the correct digest.
- Monitor checks on every run:
  - exactly 64 rnd_in_valid pulses per block
  - rnd_w for t=0..15 equals the message words
  - rnd_k at t=63 = c67178f2
